duty_slew_limiter: RTL and testbench
====================================

DUTY_SLEW_LIMITER -- requirements
Module: duty_slew_limiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of every duty value.
REQ-002 SHALL have parameter PRESC, default 4 (legal 1..16): number of tick pulses per slew step.
REQ-003 SHALL have parameter STEP, default 1 (legal 1..2^WIDTH-1): maximum change of any output per slew step.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port tick  input  1  one-clk-wide rate enable from the shared clock prescaler.
REQ-007 SHALL have port ramp_en  input  1  1 = slew-limited transition, 0 = bypass.
REQ-008 SHALL have port tgt_valid  input  1  one-cycle strobe: capture duty0..duty3 as new targets.
REQ-009 SHALL have ports duty0, duty1, duty2, duty3  input  WIDTH each  target duties for red, green, blue, white from the colour generator.
REQ-010 SHALL have ports out0, out1, out2, out3  output  WIDTH each  registered slewed duties to the PWM generator.
REQ-011 SHALL have port settled  output  1  high when all outputs equal their targets and no ramp is in progress.

Function
REQ-012 SHALL hold a target register tgtN and an output register outN per channel N=0..3, plus a prescaler counter pcnt (width ceil(log2 PRESC), minimum 1) and a two-state FSM {IDLE, RAMP}.
REQ-013 SHALL, on tgt_valid=1 with ramp_en=0, load tgtN and outN from dutyN in the next edge, force IDLE, and clear pcnt (bypass latency 1 cycle).
REQ-014 SHALL, on tgt_valid=1 with ramp_en=1, load tgtN from dutyN in the next edge; if in IDLE, enter RAMP and clear pcnt; if in RAMP, remain in RAMP without touching pcnt.
REQ-015 SHALL, in RAMP, increment pcnt on each cycle with tick=1, wrapping PRESC-1 -> 0; pcnt SHALL NOT change in IDLE or when tick=0.
REQ-016 SHALL perform a slew step on a cycle with state=RAMP, tick=1 and pcnt=PRESC-1 (for PRESC=1, every tick).
REQ-017 SHALL, per step and per channel: outN<tgtN -> outN=min(outN+STEP, tgtN); outN>tgtN -> outN=max(outN-STEP, tgtN); equal -> unchanged; intermediate math SHALL be WIDTH+1 bits so no wrap-around occurs at 0 or 2^WIDTH-1.
REQ-018 SHALL return to IDLE on the first edge at which all four outN equal tgtN, while in RAMP and no tgt_valid is present in that cycle.
REQ-019 SHALL, when tgt_valid coincides with a step, compute that step against the old targets and latch the new targets on the same edge; the following steps use the new targets.
REQ-020 SHALL, on a retarget mid-ramp, continue from the current outN values (no jump).
REQ-021 SHALL drive settled = (state=IDLE), registered; settled falls on the edge after an accepted ramp_en=1 tgt_valid, including when the new targets equal the outputs (one RAMP cycle, then IDLE).
REQ-022 SHALL ignore ramp_en changes while tgt_valid=0; a ramp in progress completes with slewing even if ramp_en falls.
REQ-023 SHALL keep all four outputs registered with no combinational path from any input to any output.

Reset
REQ-024 SHALL, while reset=1, asynchronously force outN=0, tgtN=0, pcnt=0, state=IDLE, settled=1.
REQ-025 SHALL, on reset assertion mid-ramp, abandon the ramp immediately, with no residual step after release.
REQ-026 SHALL take no ramp action on the first edge after reset release unless tgt_valid=1 at that edge.

Verification (WIDTH=8, PRESC=4, STEP=1 unless noted)
REQ-027 SHALL verify: reset, ramp_en=1, tgt_valid with duty0=3, others 0, tick every cycle -> out0 reaches 1, 2, 3 on the 4th, 8th and 12th tick; settled rises one edge after out0=3.
REQ-028 SHALL verify: ramp_en=0, tgt_valid with duties 0xFF/0x80/0x00/0x10 -> outputs equal those values one edge later; settled stays 1.
REQ-029 SHALL verify: with STEP=100 and PRESC=1, ramp from 0xFA down to 0x05 -> out0 sequence 0x96, 0x32, 0x05 (clamped, no wrap); up from 0x05 to 0xFA -> 0x69, 0xCD, 0xFA.
REQ-030 SHALL verify: mid-ramp retarget at out0=2 (target 10) to target 0, coincident with a step edge -> out0 becomes 3, then steps down 2, 1, 0, then settled=1.
REQ-031 SHALL verify: reset asserted mid-ramp between clk edges -> outputs read 0 and settled reads 1 before the next clk edge; no change after release without tgt_valid.
REQ-032 SHALL verify: tick held 0 during RAMP -> outputs and pcnt frozen for 50 cycles, and slewing resumes with correct phase when tick restarts.

Source files
------------

// File: rtl/duty_slew_limiter.sv
// -----------------------------------------------------------------------------
// duty_slew_limiter
//
// Slew-rate limiter between the colour generator and the PWM generator.
// Four duty channels (red, green, blue, white) each hold a target and a
// registered output. With ramp_en=1, a new target set is approached in steps
// of at most STEP, one step every PRESC tick pulses. With ramp_en=0, the
// targets are applied to the outputs immediately (one-cycle bypass).
//
// Ports
//   clk          system clock, rising-edge active
//   reset        asynchronous, active-high reset
//   tick         one-clk-wide rate enable from the shared prescaler
//   ramp_en      1 = slew-limited transition, 0 = bypass (sampled with tgt_valid)
//   tgt_valid    one-cycle strobe: capture duty0..duty3 as new targets
//   duty0..3     target duties (WIDTH bits each)
//   out0..3      registered slewed duties (WIDTH bits each)
//   settled      high while no ramp is in progress
// -----------------------------------------------------------------------------
module duty_slew_limiter #(
    parameter int WIDTH = 8,
    parameter int PRESC = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             ramp_en,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] duty0,
    input  logic [WIDTH-1:0] duty1,
    input  logic [WIDTH-1:0] duty2,
    input  logic [WIDTH-1:0] duty3,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             settled
);

    // Prescaler counter is at least one bit wide so PRESC=1 still elaborates.
    localparam int                PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0]     PCNT_LAST = PW'(PRESC - 1);
    localparam logic [WIDTH:0]    STEP_X    = (WIDTH + 1)'(STEP);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [WIDTH-1:0]  tgt_q [4];
    logic [WIDTH-1:0]  tgt_d [4];
    logic [WIDTH-1:0]  out_q [4];
    logic [WIDTH-1:0]  out_d [4];
    logic [WIDTH-1:0]  duty_in [4];
    logic              step_en;
    logic              all_eq;

    assign duty_in[0] = duty0;
    assign duty_in[1] = duty1;
    assign duty_in[2] = duty2;
    assign duty_in[3] = duty3;

    // One slew step toward tgt. The extra MSB keeps cur+STEP and tgt+STEP
    // from wrapping, so the result clamps at the target instead of
    // overshooting through 0 or the top of the range.
    function automatic logic [WIDTH-1:0] slew(input logic [WIDTH-1:0] cur,
                                              input logic [WIDTH-1:0] tgt);
        logic [WIDTH:0] cur_x;
        logic [WIDTH:0] tgt_x;
        logic [WIDTH:0] res_x;
        cur_x = {1'b0, cur};
        tgt_x = {1'b0, tgt};
        res_x = cur_x;
        if (cur_x < tgt_x) begin
            res_x = cur_x + STEP_X;
            if (res_x > tgt_x) begin
                res_x = tgt_x;
            end
        end else if (cur_x > tgt_x) begin
            if (cur_x < tgt_x + STEP_X) begin
                res_x = tgt_x;
            end else begin
                res_x = cur_x - STEP_X;
            end
        end
        return res_x[WIDTH-1:0];
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        pcnt_d  = pcnt_q;
        tgt_d   = tgt_q;
        out_d   = out_q;
        all_eq  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_q[i] != tgt_q[i]) begin
                all_eq = 1'b0;
            end
        end

        step_en = (state_q == RAMP) && tick && (pcnt_q == PCNT_LAST);

        if ((state_q == RAMP) && tick) begin
            pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PW'(1);
        end

        // A step always uses the targets held before this edge; a coincident
        // tgt_valid only affects the steps that follow.
        if (step_en) begin
            for (int i = 0; i < 4; i++) begin
                out_d[i] = slew(out_q[i], tgt_q[i]);
            end
        end

        if (tgt_valid) begin
            tgt_d = duty_in;
            if (!ramp_en) begin
                // Bypass overrides any step that would have happened.
                out_d   = duty_in;
                state_d = IDLE;
                pcnt_d  = '0;
            end else if (state_q == IDLE) begin
                state_d = RAMP;
                pcnt_d  = '0;
            end
        end else if ((state_q == RAMP) && all_eq) begin
            state_d = IDLE;
        end
    end

    // NOTE: target/output arrays are individual flops, not a RAM, so
    // clearing them in the async reset branch is legitimate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                tgt_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            tgt_q   <= tgt_d;
            out_q   <= out_d;
        end
    end

    assign out0    = out_q[0];
    assign out1    = out_q[1];
    assign out2    = out_q[2];
    assign out3    = out_q[3];
    assign settled = (state_q == IDLE);

endmodule

// File: tb/tb_duty_slew_limiter.sv
// -----------------------------------------------------------------------------
// tb_duty_slew_limiter
//
// Self-checking bench for duty_slew_limiter. A behavioural model built from
// plain integer arithmetic tracks targets, outputs, the tick phase and the
// ramp/idle condition; directed scenarios plus a randomized run are compared
// against it, and a second instance (STEP=100, PRESC=1) checks clamping.
// -----------------------------------------------------------------------------
module tb_duty_slew_limiter;

    localparam int P = 4;
    localparam int S = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, ramp_en, tgt_valid;
    logic [7:0] duty [4];
    logic [7:0] out0, out1, out2, out3;
    logic       settled;

    logic       b_tick, b_ramp_en, b_tgt_valid;
    logic [7:0] b_duty0;
    logic [7:0] b_out0, b_out1, b_out2, b_out3;
    logic       b_settled;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_out [4];
    int m_tgt [4];
    bit m_ramp;
    int m_phase;

    duty_slew_limiter #(.WIDTH(8), .PRESC(P), .STEP(S)) dut (
        .clk(clk), .reset(reset), .tick(tick), .ramp_en(ramp_en),
        .tgt_valid(tgt_valid),
        .duty0(duty[0]), .duty1(duty[1]), .duty2(duty[2]), .duty3(duty[3]),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .settled(settled)
    );

    duty_slew_limiter #(.WIDTH(8), .PRESC(1), .STEP(100)) dut_big (
        .clk(clk), .reset(reset), .tick(b_tick), .ramp_en(b_ramp_en),
        .tgt_valid(b_tgt_valid),
        .duty0(b_duty0), .duty1(8'h00), .duty2(8'h00), .duty3(8'h00),
        .out0(b_out0), .out1(b_out1), .out2(b_out2), .out3(b_out3),
        .settled(b_settled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int approach(int cur, int tgt, int step);
        if (cur < tgt) return (tgt - cur > step) ? cur + step : tgt;
        if (cur > tgt) return (cur - tgt > step) ? cur - step : tgt;
        return cur;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_out[i] = 0;
            m_tgt[i] = 0;
        end
        m_ramp  = 1'b0;
        m_phase = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_edge();
        bit do_step;
        bit done;
        do_step = m_ramp && tick && (m_phase == P - 1);
        done    = m_ramp;
        for (int i = 0; i < 4; i++) begin
            if (m_out[i] != m_tgt[i]) done = 1'b0;
        end
        if (m_ramp && tick) m_phase = (m_phase + 1) % P;
        if (do_step) begin
            for (int i = 0; i < 4; i++) m_out[i] = approach(m_out[i], m_tgt[i], S);
        end
        if (tgt_valid) begin
            for (int i = 0; i < 4; i++) m_tgt[i] = int'(duty[i]);
            if (!ramp_en) begin
                for (int i = 0; i < 4; i++) m_out[i] = int'(duty[i]);
                m_ramp  = 1'b0;
                m_phase = 0;
            end else if (!m_ramp) begin
                m_ramp  = 1'b1;
                m_phase = 0;
            end
        end else if (done) begin
            m_ramp = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out0"}, out0, m_out[0]);
        chk({tag, ".out1"}, out1, m_out[1]);
        chk({tag, ".out2"}, out2, m_out[2]);
        chk({tag, ".out3"}, out3, m_out[3]);
        chk({tag, ".settled"}, settled, m_ramp ? 0 : 1);
        chk({tag, ".pcnt"}, dut.pcnt_q, m_phase);
    endtask

    // One clock edge: update the model, then sample #1 after the edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
        duty[0] = 8'(d0);
        duty[1] = 8'(d1);
        duty[2] = 8'(d2);
        duty[3] = 8'(d3);
    endtask

    initial begin
        reset = 1'b1;
        tick = 1'b0; ramp_en = 1'b0; tgt_valid = 1'b0;
        set_duty(0, 0, 0, 0);
        b_tick = 1'b0; b_ramp_en = 1'b0; b_tgt_valid = 1'b0; b_duty0 = 8'h00;
        m_reset();

        // ---- Reset state ----
        repeat (2) cycle("reset");
        reset = 1'b0;
        cycle("post_reset");

        // ---- Ramp 0 -> 3 on channel 0, tick every cycle ----
        ramp_en = 1'b1; tgt_valid = 1'b1; tick = 1'b1;
        set_duty(3, 0, 0, 0);
        cycle("ramp_load");
        chk("ramp_load.settled_low", settled, 0);
        tgt_valid = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            cycle("ramp_up");
            if (k == 4)  chk("ramp_up.tick4", out0, 1);
            if (k == 8)  chk("ramp_up.tick8", out0, 2);
            if (k == 12) begin
                chk("ramp_up.tick12", out0, 3);
                chk("ramp_up.tick12_busy", settled, 0);
            end
            if (k == 13) chk("ramp_up.settled", settled, 1);
        end

        // ---- Bypass load ----
        ramp_en = 1'b0; tgt_valid = 1'b1;
        set_duty(8'hFF, 8'h80, 8'h00, 8'h10);
        cycle("bypass");
        chk("bypass.out0", out0, 8'hFF);
        chk("bypass.out1", out1, 8'h80);
        chk("bypass.out2", out2, 8'h00);
        chk("bypass.out3", out3, 8'h10);
        chk("bypass.settled", settled, 1);

        // ---- Retarget coincident with a step ----
        set_duty(0, 0, 0, 0);
        cycle("retgt_clear");
        ramp_en = 1'b1;
        set_duty(10, 0, 0, 0);
        cycle("retgt_load");
        tgt_valid = 1'b0;
        repeat (8) cycle("retgt_up");
        chk("retgt.at2", out0, 2);
        repeat (3) cycle("retgt_up");
        tgt_valid = 1'b1;
        set_duty(0, 0, 0, 0);
        cycle("retgt_edge");
        chk("retgt.step_old_tgt", out0, 3);
        tgt_valid = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            cycle("retgt_down");
            if (k == 4)  chk("retgt.down2", out0, 2);
            if (k == 8)  chk("retgt.down1", out0, 1);
            if (k == 12) chk("retgt.down0", out0, 0);
            if (k == 13) chk("retgt.settled", settled, 1);
        end

        // ---- Reset mid-ramp, between edges ----
        tgt_valid = 1'b1;
        set_duty(0, 200, 0, 0);
        cycle("rst_load");
        tgt_valid = 1'b0;
        repeat (10) cycle("rst_ramp");
        chk("rst.pre_out1", out1, 2);
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        chk("rst.async_out1", out1, 0);
        chk("rst.async_settled", settled, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) cycle("rst_after");
        chk("rst.after_out1", out1, 0);

        // ---- Tick frozen during RAMP ----
        tgt_valid = 1'b1;
        set_duty(0, 0, 5, 0);
        cycle("freeze_load");
        tgt_valid = 1'b0;
        repeat (6) cycle("freeze_pre");
        chk("freeze.pre_out2", out2, 1);
        chk("freeze.pre_pcnt", dut.pcnt_q, 2);
        tick = 1'b0;
        repeat (50) cycle("freeze_hold");
        chk("freeze.hold_out2", out2, 1);
        chk("freeze.hold_pcnt", dut.pcnt_q, 2);
        tick = 1'b1;
        cycle("freeze_resume");
        chk("freeze.resume1_out2", out2, 1);
        cycle("freeze_resume");
        chk("freeze.resume2_out2", out2, 2);
        repeat (14) cycle("freeze_tail");
        chk("freeze.done_out2", out2, 5);

        // ---- Randomized run against the model ----
        for (int k = 0; k < 400; k++) begin
            tick      = ($urandom_range(0, 3) != 0);
            tgt_valid = ($urandom_range(0, 23) == 0);
            ramp_en   = ($urandom_range(0, 4) != 0);
            set_duty($urandom_range(0, 12), $urandom_range(0, 12),
                     (k % 2 == 0) ? $urandom_range(0, 255) : 0, $urandom_range(0, 6));
            cycle("random");
        end
        tgt_valid = 1'b0;
        tick = 1'b0;

        // ---- Clamping instance: STEP=100, PRESC=1 ----
        b_tick = 1'b1; b_ramp_en = 1'b0; b_tgt_valid = 1'b1; b_duty0 = 8'hFA;
        cycle("big_bypass");
        chk("big.bypass", b_out0, 8'hFA);
        b_ramp_en = 1'b1; b_duty0 = 8'h05;
        cycle("big_load_down");
        b_tgt_valid = 1'b0;
        cycle("big_down");
        chk("big.down1", b_out0, 8'h96);
        cycle("big_down");
        chk("big.down2", b_out0, 8'h32);
        cycle("big_down");
        chk("big.down3", b_out0, 8'h05);
        cycle("big_down");
        chk("big.down_settled", b_settled, 1);
        b_tgt_valid = 1'b1; b_duty0 = 8'hFA;
        cycle("big_load_up");
        b_tgt_valid = 1'b0;
        cycle("big_up");
        chk("big.up1", b_out0, 8'h69);
        cycle("big_up");
        chk("big.up2", b_out0, 8'hCD);
        cycle("big_up");
        chk("big.up3", b_out0, 8'hFA);
        cycle("big_up");
        chk("big.up_settled", b_settled, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
